conv_mac_sequencer: RTL and testbench
=====================================

// Module: conv_mac_sequencer
// PURPOSE
//  Downstream consumer of the image and kernel RAMs in the single-multiplier convolution path.
//  After start, it walks every valid 2-D window position and drives the RAM read addresses.
//  One multiply-accumulate is performed per cycle using the single shared multiplier.
//  Each finished window sum is handed out on a valid/ready stream; done pulses after the last window.
// PARAMETERS
//  N      8   pixel/weight width, signed two's complement
//  M      6   RAM address width; IMG_W*IMG_H <= 2**M and KS*KS <= 2**M
//  IMG_W  8   image width (columns)
//  IMG_H  8   image height (rows)
//  KS     3   square kernel side
//  ACC_W  20  accumulator/result width; must be >= 2*N + clog2(KS*KS)
// PORTS
//  clk        in   1      clock, rising edge
//  rst        in   1      reset, asynchronous, active-high
//  start      in   1      one-cycle request to begin a full-image convolution
//  busy       out  1      high in every state except IDLE
//  done       out  1      one-cycle pulse after the last result is accepted
//  img_rd     out  1      image RAM read enable
//  img_adr    out  M      image RAM address, row-major
//  img_data   in   N      image RAM data (combinational read)
//  ker_rd     out  1      kernel RAM read enable
//  ker_adr    out  M      kernel RAM address, row-major
//  ker_data   in   N      kernel RAM data (combinational read)
//  out_valid  out  1      result available
//  out_ready  in   1      consumer accepts result
//  out_data   out  ACC_W  signed window sum
//  out_row    out  M      output row index of out_data
//  out_col    out  M      output column index of out_data
// BEHAVIOUR
//  Output grid is OH = IMG_H-KS+1 rows by OW = IMG_W-KS+1 columns ("valid" convolution, no padding).
//  Reset: state IDLE; all counters and acc cleared; all outputs 0.
//  State IDLE
//   - start=1 -> MAC; r=c=kr=kc=0.
//  State MAC (KS*KS cycles)
//   - img_rd=ker_rd=1.
//   - img_adr = (r+kr)*IMG_W + (c+kc); ker_adr = kr*KS + kc.
//   - prod = sign-extended img_data*ker_data.
//   - First tap (kr=kc=0): acc <= prod. Other taps: acc <= acc + prod.
//   - kc wraps at KS-1, incrementing kr. After tap (KS-1,KS-1) -> OUT.
//  State OUT
//   - out_valid=1; out_data = acc; out_row=r; out_col=c. rd=0, adr=0.
//   - Values stay stable while out_ready=0.
//   - On out_valid & out_ready: c++; if c==OW-1 then c=0 and r++.
//   - Last window (r=OH-1, c=OW-1) -> DONE; otherwise -> MAC with kr=kc=0.
//  State DONE
//   - done=1 for exactly one cycle, then -> IDLE; busy=0 from IDLE onward.
//  Timing: latency per window = KS*KS cycles plus 1 OUT cycle minimum.
//   With out_ready held 1, the job takes OH*OW*(KS*KS+1)+1 cycles from start to done.
//  Boundaries
//   - start while busy is ignored.
//   - rd and adr are 0 outside MAC.
//   - Accumulation is not saturated; ACC_W sizing guarantees no overflow.
//   - rst mid-operation aborts immediately to IDLE; no done pulse is produced.
//   - out_ready is a don't-care outside OUT.
// CONFIGURATION
//  CONV_RELU_EN
//   - Defined: out_data = (acc<0) ? 0 : acc (ReLU applied in OUT); acc itself is unchanged.
//   - Undefined: out_data = acc, raw signed sum.
// STRUCTURE
//  Package conv_pkg:
//   - state encoding localparams (IDLE, MAC, OUT, DONE)
//   - clog2 function
//   - OW/OH derivation helpers
//  Sub-module conv_addr_gen:
//   - nested r/c/kr/kc counters plus both address computations
//   - advances on tap_en / win_en; flags last_tap and last_win
//  Top level holds the FSM, multiplier, accumulator, and output register.
// TESTING (IMG_W=IMG_H=4, KS=3, N=8, M=6; image[i]=i for i=0..15)
//  1. Kernel all +1, out_ready=1
//     -> results (0,0)=45, (0,1)=54, (1,0)=81, (1,1)=90 in that order
//     -> done pulses 41 cycles after start
//  2. Same as 1, out_ready=0 for 5 cycles at the first OUT
//     -> out_valid and out_data=45 held for those cycles, img_rd=0
//     -> the next result, 54, follows normally
//  3. Kernel all -1
//     -> CONV_RELU_EN undefined: -45, -54, -81, -90
//     -> CONV_RELU_EN defined: all four results 0
//  4. Assert rst during the 5th MAC cycle of window 2
//     -> next cycle busy=0, out_valid=0, adr=0
//     -> a new start reproduces scenario 1 exactly
//  5. Pulse start again while busy
//     -> ignored; still exactly 4 results and one done pulse
//  6. Kernel one-hot at tap (1,1)
//     -> results 5, 6, 9, 10 (center pixels), confirming address mapping

Source files
------------

// File: rtl/conv_pkg.sv
// conv_pkg: shared definitions for the single-multiplier convolution sequencer.
//   - state encoding of the sequencer FSM (IDLE, MAC, OUT, DONE)
//   - clog2 helper for sizing
//   - output-grid derivation for a "valid" (unpadded) convolution
package conv_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MAC  = 2'd1;
  localparam logic [1:0] ST_OUT  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    MAC  = ST_MAC,
    OUT  = ST_OUT,
    DONE = ST_DONE
  } state_t;

  // Smallest r with 2**r >= v.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << r) < 64'(v)) r = r + 1;
    end
    return r;
  endfunction

  // Output columns of an unpadded convolution.
  function automatic int out_w(input int img_w, input int ks);
    return img_w - ks + 1;
  endfunction

  // Output rows of an unpadded convolution.
  function automatic int out_h(input int img_h, input int ks);
    return img_h - ks + 1;
  endfunction

endpackage

// File: rtl/conv_mac_sequencer_if.sv
// conv_mac_sequencer_if: bundle of the sequencer's control, RAM-read and
// result-stream signals.
//   start/busy/done              job control
//   img_rd/img_adr/img_data      image RAM read port (combinational data)
//   ker_rd/ker_adr/ker_data      kernel RAM read port (combinational data)
//   out_valid/out_ready/out_data result stream with out_row/out_col position
// Modports: master = the sequencer, slave = its environment.
interface conv_mac_sequencer_if #(
  parameter int N     = 8,
  parameter int M     = 6,
  parameter int ACC_W = 20
);
  logic                    start;
  logic                    busy;
  logic                    done;
  logic                    img_rd;
  logic [M-1:0]            img_adr;
  logic signed [N-1:0]     img_data;
  logic                    ker_rd;
  logic [M-1:0]            ker_adr;
  logic signed [N-1:0]     ker_data;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [ACC_W-1:0] out_data;
  logic [M-1:0]            out_row;
  logic [M-1:0]            out_col;

  modport master (
    input  start,
    output busy, done,
    output img_rd, img_adr,
    input  img_data,
    output ker_rd, ker_adr,
    input  ker_data,
    output out_valid,
    input  out_ready,
    output out_data, out_row, out_col
  );

  modport slave (
    output start,
    input  busy, done,
    input  img_rd, img_adr,
    output img_data,
    input  ker_rd, ker_adr,
    output ker_data,
    input  out_valid,
    output out_ready,
    input  out_data, out_row, out_col
  );
endinterface

// File: rtl/conv_addr_gen.sv
// conv_addr_gen: window/tap walker for the convolution sequencer.
// Nested counters r (output row), c (output column), kr/kc (kernel tap).
//   clk, rst  clock, asynchronous active-high reset
//   clr       restart the walk at window (0,0), tap (0,0)
//   tap_en    advance to the next kernel tap (kc fastest, then kr)
//   win_en    advance to the next output window (c fastest, then r)
//   img_adr   (r+kr)*IMG_W + (c+kc), row-major image address
//   ker_adr   kr*KS + kc, row-major kernel address
//   row, col  current output window position
//   last_tap  current tap is (KS-1, KS-1)
//   last_win  current window is (OH-1, OW-1)
module conv_addr_gen
  import conv_pkg::*;
#(
  parameter int M     = 6,
  parameter int IMG_W = 8,
  parameter int IMG_H = 8,
  parameter int KS    = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         tap_en,
  input  logic         win_en,
  output logic [M-1:0] img_adr,
  output logic [M-1:0] ker_adr,
  output logic [M-1:0] row,
  output logic [M-1:0] col,
  output logic         last_tap,
  output logic         last_win
);
  localparam int OW = out_w(IMG_W, KS);
  localparam int OH = out_h(IMG_H, KS);

  logic [M-1:0] r, c, kr, kc;

  assign last_tap = (kr == M'(KS - 1)) && (kc == M'(KS - 1));
  assign last_win = (r == M'(OH - 1)) && (c == M'(OW - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r  <= '0;
      c  <= '0;
      kr <= '0;
      kc <= '0;
    end else if (clr) begin
      r  <= '0;
      c  <= '0;
      kr <= '0;
      kc <= '0;
    end else begin
      // Taps wrap back to (0,0) after the last one, so every window starts clean.
      if (tap_en) begin
        if (kc == M'(KS - 1)) begin
          kc <= '0;
          kr <= last_tap ? '0 : kr + 1'b1;
        end else begin
          kc <= kc + 1'b1;
        end
      end
      if (win_en) begin
        if (c == M'(OW - 1)) begin
          c <= '0;
          r <= r + 1'b1;
        end else begin
          c <= c + 1'b1;
        end
      end
    end
  end

  // Both addresses are bounded by the RAM sizes, so M bits hold them exactly.
  assign img_adr = M'((int'(r) + int'(kr)) * IMG_W + int'(c) + int'(kc));
  assign ker_adr = M'(int'(kr) * KS + int'(kc));
  assign row     = r;
  assign col     = c;

endmodule

// File: rtl/conv_mac_sequencer.sv
// conv_mac_sequencer: walks every valid KSxKS window of an IMG_W x IMG_H image,
// performing one multiply-accumulate per cycle on a single shared multiplier,
// and streams each window sum out with its (row, col) position.
//   clk, rst  clock, asynchronous active-high reset (aborts any job, no done)
//   bus       conv_mac_sequencer_if.master: start/busy/done, image and kernel
//             RAM read ports, out_valid/out_ready/out_data/out_row/out_col
// Optional build macro CONV_RELU_EN: when defined, out_data is clamped at 0
// for negative sums (the accumulator itself keeps the raw value).
module conv_mac_sequencer
  import conv_pkg::*;
#(
  parameter int N     = 8,
  parameter int M     = 6,
  parameter int IMG_W = 8,
  parameter int IMG_H = 8,
  parameter int KS    = 3,
  parameter int ACC_W = 20
) (
  input  logic                 clk,
  input  logic                 rst,
  conv_mac_sequencer_if.master bus
);
  state_t state_q, state_d;

  logic                    clr, tap_en, win_en;
  logic                    last_tap, last_win;
  logic [M-1:0]            img_adr_raw, ker_adr_raw, row, col;
  logic signed [2*N-1:0]   prod_p0;
  logic signed [ACC_W-1:0] acc_p1;

  function automatic logic signed [ACC_W-1:0] sext_prod(input logic signed [2*N-1:0] p);
    return {{(ACC_W - 2*N){p[2*N-1]}}, p};
  endfunction

  function automatic logic signed [ACC_W-1:0] relu(input logic signed [ACC_W-1:0] v);
`ifdef CONV_RELU_EN
    return v[ACC_W-1] ? '0 : v;
`else
    return v;
`endif
  endfunction

  conv_addr_gen #(
    .M    (M),
    .IMG_W(IMG_W),
    .IMG_H(IMG_H),
    .KS   (KS)
  ) u_addr (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr),
    .tap_en  (tap_en),
    .win_en  (win_en),
    .img_adr (img_adr_raw),
    .ker_adr (ker_adr_raw),
    .row     (row),
    .col     (col),
    .last_tap(last_tap),
    .last_win(last_win)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // start is only honoured from IDLE; it is ignored while a job runs.
  always_comb begin
    state_d = state_q;
    clr     = 1'b0;
    tap_en  = 1'b0;
    win_en  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          clr     = 1'b1;
          state_d = MAC;
        end
      end
      MAC: begin
        tap_en = 1'b1;
        if (last_tap) state_d = OUT;
      end
      OUT: begin
        if (bus.out_ready) begin
          win_en  = 1'b1;
          state_d = last_win ? DONE : MAC;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---- p0: product of the RAM read data (combinational RAMs) ----
  assign prod_p0 = (2*N)'(bus.img_data) * (2*N)'(bus.ker_data);

  // ---- p1: accumulator; tap (0,0) is the only one with kernel address 0 ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_p1 <= '0;
    end else if (state_q == MAC) begin
      if (ker_adr_raw == '0) acc_p1 <= sext_prod(prod_p0);
      else                   acc_p1 <= acc_p1 + sext_prod(prod_p0);
    end
  end

  // Outputs are decoded from the registered state, so they are all 0 in reset.
  always_comb begin
    bus.busy      = (state_q != IDLE);
    bus.done      = (state_q == DONE);
    bus.img_rd    = (state_q == MAC);
    bus.ker_rd    = (state_q == MAC);
    bus.img_adr   = (state_q == MAC) ? img_adr_raw : '0;
    bus.ker_adr   = (state_q == MAC) ? ker_adr_raw : '0;
    bus.out_valid = (state_q == OUT);
    bus.out_data  = (state_q == OUT) ? relu(acc_p1) : '0;
    bus.out_row   = (state_q == OUT) ? row : '0;
    bus.out_col   = (state_q == OUT) ? col : '0;
  end

endmodule

// File: tb/tb_conv_mac_sequencer.sv
// Testbench for conv_mac_sequencer on a 4x4 image (pixel i = i) with a 3x3 kernel.
module tb_conv_mac_sequencer;
  import conv_pkg::*;

  localparam int N     = 8;
  localparam int M     = 6;
  localparam int IMG_W = 4;
  localparam int IMG_H = 4;
  localparam int KS    = 3;
  localparam int ACC_W = 20;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  conv_mac_sequencer_if #(.N(N), .M(M), .ACC_W(ACC_W)) bus ();

  conv_mac_sequencer #(
    .N(N), .M(M), .IMG_W(IMG_W), .IMG_H(IMG_H), .KS(KS), .ACC_W(ACC_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic signed [N-1:0] img_mem [16];
  logic signed [N-1:0] ker_mem [16];
  assign bus.img_data = img_mem[bus.img_adr[3:0]];
  assign bus.ker_data = ker_mem[bus.ker_adr[3:0]];

  typedef struct {
    logic [8:0][N-1:0]     k;
    logic [3:0][ACC_W-1:0] ex;   // raw sums for windows (0,0),(0,1),(1,0),(1,1)
  } vec_t;

  typedef struct {
    logic signed [ACC_W-1:0] d;
    logic [M-1:0]            r;
    logic [M-1:0]            c;
  } exp_t;

  vec_t tbl [5];
  exp_t sb [$];

  int n_cmp  = 0;
  int n_fail = 0;
  int n_done = 0;
  int n_res  = 0;
  int cyc    = 0;
  int c0     = 0;

  function automatic logic signed [ACC_W-1:0] ref_out(input logic signed [ACC_W-1:0] v);
`ifdef CONV_RELU_EN
    return (v < 0) ? '0 : v;
`else
    return v;
`endif
  endfunction

  task automatic chk(input string nm, input longint act, input longint req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", nm, act, req);
    end
  endtask

  // One clock: score a handshake happening at this edge, then move past it.
  task automatic tick();
    exp_t e;
    if (bus.out_valid && bus.out_ready) begin
      n_res++;
      n_cmp++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL result_unexpected: got %0d at (%0d,%0d), required none",
                 bus.out_data, bus.out_row, bus.out_col);
      end else begin
        e = sb.pop_front();
        if (bus.out_data !== e.d || bus.out_row !== e.r || bus.out_col !== e.c) begin
          n_fail++;
          $display("FAIL result: got %0d at (%0d,%0d), required %0d at (%0d,%0d)",
                   bus.out_data, bus.out_row, bus.out_col, e.d, e.r, e.c);
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (bus.done) n_done++;
  endtask

  // Load kernel idx, queue its four expected results and raise start for one edge.
  task automatic begin_job(input int idx);
    exp_t e;
    for (int i = 0; i < 9; i++) ker_mem[i] = tbl[idx].k[i];
    for (int w = 0; w < 4; w++) begin
      e.d = ref_out(tbl[idx].ex[w]);
      e.r = M'(w / 2);
      e.c = M'(w % 2);
      sb.push_back(e);
    end
    c0 = cyc;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  // Run until done; latency counts edges from the one at which start was driven.
  task automatic finish_job(input string nm, input int req_lat);
    bit got;
    got = 1'b0;
    while (!got && (cyc - c0) < 400) begin
      if (bus.done) got = 1'b1;
      else tick();
    end
    chk({nm, "_done_seen"}, got, 1);
    if (req_lat > 0) chk({nm, "_latency"}, cyc - c0, req_lat);
    chk({nm, "_results_left"}, sb.size(), 0);
    tick();
    chk({nm, "_done_one_cycle"}, bus.done, 0);
    chk({nm, "_busy_after"}, bus.busy, 0);
  endtask

  task automatic wait_valid(input string nm);
    int n;
    n = 0;
    while (!bus.out_valid && n < 50) begin
      tick();
      n++;
    end
    chk({nm, "_out_valid_seen"}, bus.out_valid, 1);
  endtask

  initial begin
    int nd, nr;
    bit busy_seen;

    for (int i = 0; i < 16; i++) begin
      img_mem[i] = N'(i);
      ker_mem[i] = '0;
    end

    // Kernel table with hand-derived window sums over the 0..15 ramp image.
    tbl[0].k  = {9{8'sd1}};
    tbl[0].ex = {20'sd90, 20'sd81, 20'sd54, 20'sd45};
    tbl[1].k  = {9{-8'sd1}};
    tbl[1].ex = {-20'sd90, -20'sd81, -20'sd54, -20'sd45};
    tbl[2].k    = '0;
    tbl[2].k[4] = 8'sd1;
    tbl[2].ex = {20'sd10, 20'sd9, 20'sd6, 20'sd5};
    tbl[3].k    = '0;
    tbl[3].k[0] = 8'sd2;
    tbl[3].k[8] = -8'sd3;
    tbl[3].ex = {-20'sd35, -20'sd34, -20'sd31, -20'sd30};
    tbl[4].k  = {9{-8'sd128}};
    tbl[4].ex = {-20'sd11520, -20'sd10368, -20'sd6912, -20'sd5760};

    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_img_rd", bus.img_rd, 0);
    chk("rst_ker_rd", bus.ker_rd, 0);
    chk("rst_img_adr", bus.img_adr, 0);
    chk("rst_ker_adr", bus.ker_adr, 0);
    chk("rst_out_data", bus.out_data, 0);
    rst = 1'b0;
    tick();
    chk("idle_busy", bus.busy, 0);

    // Table: each kernel as a full job with out_ready held high.
    for (int i = 0; i < 5; i++) begin
      nd = n_done;
      nr = n_res;
      begin_job(i);
      chk("first_mac_img_rd", bus.img_rd, 1);
      finish_job($sformatf("vec%0d", i), 41);
      chk($sformatf("vec%0d_results", i), n_res - nr, 4);
      chk($sformatf("vec%0d_done_pulses", i), n_done - nd, 1);
    end

    // Back-pressure on the first result: held stable, no RAM reads.
    bus.out_ready = 1'b0;
    begin_job(0);
    wait_valid("stall");
    for (int i = 0; i < 5; i++) begin
      chk("stall_out_valid", bus.out_valid, 1);
      chk("stall_out_data", bus.out_data, 45);
      chk("stall_img_rd", bus.img_rd, 0);
      chk("stall_img_adr", bus.img_adr, 0);
      tick();
    end
    bus.out_ready = 1'b1;
    finish_job("stall", 46);

    // Reset during the 5th MAC cycle of window 2 aborts without done.
    nd = n_done;
    begin_job(0);
    wait_valid("abort");
    tick();
    repeat (4) tick();
    chk("abort_in_mac", bus.img_rd, 1);
    chk("abort_ker_adr_tap4", bus.ker_adr, 4);
    rst = 1'b1;
    tick();
    chk("abort_busy", bus.busy, 0);
    chk("abort_out_valid", bus.out_valid, 0);
    chk("abort_img_adr", bus.img_adr, 0);
    chk("abort_ker_adr", bus.ker_adr, 0);
    rst = 1'b0;
    sb.delete();
    repeat (3) tick();
    chk("abort_no_done", n_done - nd, 0);
    begin_job(0);
    finish_job("after_abort", 41);

    // start pulses while busy must be ignored.
    nd = n_done;
    nr = n_res;
    begin_job(0);
    repeat (4) tick();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_valid("restart");
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    finish_job("restart", 41);
    busy_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.busy) busy_seen = 1'b1;
    end
    chk("restart_stays_idle", busy_seen, 0);
    chk("restart_results", n_res - nr, 4);
    chk("restart_done_pulses", n_done - nd, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
